// File: rtl/mem_port_arbiter.sv
// Unified memory-port arbiter: data over fetch, one access in flight,
// fixed read latency, one-cycle ack and combinational pipeline stall.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sel_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_d     <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_req) begin
            sel_d     <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= ISSUE;
          end else if (if_req) begin
            sel_d    <= 1'b0;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          // stores complete without waiting on read data
          if (mem_we) begin
            d_ack  <= sel_d;
            if_ack <= ~sel_d;
            state  <= DONE;
          end else begin
            cnt   <= CW'(MEM_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            if (sel_d) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 2 and 1) against a
// transaction-timeline model, directed scenarios plus random traffic.
module tb_mem_port_arbiter;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]       if_req, d_req, d_we;
  logic [1:0][31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]       if_ack, d_ack, mem_en, mem_we, stall;
  logic [1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]),
    .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .stall(stall[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]),
    .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .stall(stall[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h40) return 32'h2008_0005;
    if (a == 32'h100) return 32'h0000_FFFF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] raddr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return 32'h40;
      1: return 32'h44;
      2: return 32'h100;
      3: return 32'h104;
      default: return r & ~32'h3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // timeline model: each granted access has an issue cycle and a done cycle
  bit [1:0]         busy, gsel_d, gwe;
  int               issue_c[2], done_c[2];
  logic [1:0][31:0] gaddr, ex_ird, ex_drd, ex_ma, ex_mw;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        busy[k]   <= 1'b0;
        ex_ird[k] <= '0;
        ex_drd[k] <= '0;
        ex_ma[k]  <= '0;
        ex_mw[k]  <= '0;
      end else if (!busy[k]) begin
        if (d_req[k] || if_req[k]) begin
          busy[k]    <= 1'b1;
          gsel_d[k]  <= d_req[k];
          gwe[k]     <= d_req[k] & d_we[k];
          gaddr[k]   <= d_req[k] ? d_addr[k] : if_addr[k];
          ex_ma[k]   <= d_req[k] ? d_addr[k] : if_addr[k];
          if (d_req[k]) ex_mw[k] <= d_wdata[k];
          issue_c[k] <= cyc + 1;
          done_c[k]  <= (d_req[k] && d_we[k]) ? cyc + 2
                                              : cyc + 2 + lat_of(k);
        end
      end else begin
        if (!gwe[k] && cyc + 1 == done_c[k]) begin
          if (gsel_d[k]) ex_drd[k] <= rom(gaddr[k]);
          else ex_ird[k] <= rom(gaddr[k]);
        end
        if (cyc == done_c[k]) busy[k] <= 1'b0;
      end
    end
  end

  // memory: data valid only in the cycle MEM_LAT after the strobe
  bit [1:0]         pend, prev_ia, prev_da;
  int               en_c[2];
  logic [1:0][31:0] en_a;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      prev_ia[k] <= if_ack[k];
      prev_da[k] <= d_ack[k];
      if (!rst) pend[k] <= 1'b0;
      else if (mem_en[k]) begin
        pend[k] <= 1'b1;
        en_c[k] <= cyc;
        en_a[k] <= mem_addr[k];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (pend[k] && cyc == en_c[k] + lat_of(k))
        mem_rdata[k] <= rom(en_a[k]);
      else
        mem_rdata[k] <= $urandom;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic en, we, ia, da, st;
      logic [31:0] ma, mw, ird, drd;
      if (!rst) begin
        en = 0; we = 0; ia = 0; da = 0;
        ma = 0; mw = 0; ird = 0; drd = 0;
      end else begin
        en  = busy[k] && cyc == issue_c[k];
        we  = en && gwe[k];
        ia  = busy[k] && cyc == done_c[k] && !gsel_d[k];
        da  = busy[k] && cyc == done_c[k] && gsel_d[k];
        ma  = ex_ma[k];
        mw  = ex_mw[k];
        ird = ex_ird[k];
        drd = ex_drd[k];
      end
      st = (if_req[k] & ~ia) | (d_req[k] & ~da);
      chk($sformatf("u%0d.mem_en", k), 32'(mem_en[k]), 32'(en));
      chk($sformatf("u%0d.mem_we", k), 32'(mem_we[k]), 32'(we));
      chk($sformatf("u%0d.if_ack", k), 32'(if_ack[k]), 32'(ia));
      chk($sformatf("u%0d.d_ack", k), 32'(d_ack[k]), 32'(da));
      chk($sformatf("u%0d.stall", k), 32'(stall[k]), 32'(st));
      chk($sformatf("u%0d.mem_addr", k), mem_addr[k], ma);
      chk($sformatf("u%0d.mem_wdata", k), mem_wdata[k], mw);
      chk($sformatf("u%0d.if_rdata", k), if_rdata[k], ird);
      chk($sformatf("u%0d.d_rdata", k), d_rdata[k], drd);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_req = '0;
    d_req  = '0;
    d_we   = '0;
  endtask

  int rst_cnt;

  initial begin
    quiet();
    if_addr = '0;
    d_addr  = '0;
    d_wdata = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en[0]), 32'd0);
    chk("rst_if_rdata", if_rdata[0], 32'd0);
    next();
    rst = 1'b1;
    next();
    next();

    // single fetch
    if_req[0] = 1'b1;
    if_addr[0] = 32'h40;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("f1_en", 32'(mem_en[0]), 32'd1);
        chk("f1_we", 32'(mem_we[0]), 32'd0);
        chk("f1_addr", mem_addr[0], 32'h40);
      end else chk("f1_en_lo", 32'(mem_en[0]), 32'd0);
      if (k == 4) begin
        chk("f1_ack", 32'(if_ack[0]), 32'd1);
        chk("f1_rdata", if_rdata[0], 32'h2008_0005);
        chk("f1_stall_lo", 32'(stall[0]), 32'd0);
      end else if (k < 4) chk("f1_stall_hi", 32'(stall[0]), 32'd1);
      next();
      if (k == 4) if_req[0] = 1'b0;
    end
    next();

    // contention: load beats fetch
    d_req[0] = 1'b1;
    d_we[0] = 1'b0;
    d_addr[0] = 32'h100;
    if_req[0] = 1'b1;
    if_addr[0] = 32'h44;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 4) begin
        chk("c_dack", 32'(d_ack[0]), 32'd1);
        chk("c_drdata", d_rdata[0], 32'h0000_FFFF);
      end
      if (k == 6) begin
        chk("c_fen", 32'(mem_en[0]), 32'd1);
        chk("c_faddr", mem_addr[0], 32'h44);
      end
      if (k == 8) chk("c_iack_lo", 32'(if_ack[0]), 32'd0);
      if (k == 9) chk("c_iack", 32'(if_ack[0]), 32'd1);
      next();
      if (k == 4) d_req[0] = 1'b0;
      if (k == 9) if_req[0] = 1'b0;
    end
    next();

    // store
    d_req[0] = 1'b1;
    d_we[0] = 1'b1;
    d_addr[0] = 32'h104;
    d_wdata[0] = 32'hDEAD_BEEF;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("s_en", 32'(mem_en[0]), 32'd1);
        chk("s_we", 32'(mem_we[0]), 32'd1);
        chk("s_addr", mem_addr[0], 32'h104);
        chk("s_wdata", mem_wdata[0], 32'hDEAD_BEEF);
      end
      if (k == 2) begin
        chk("s_ack", 32'(d_ack[0]), 32'd1);
        chk("s_drdata", d_rdata[0], 32'h0000_FFFF);
      end
      if (k == 3) chk("s_ack_lo", 32'(d_ack[0]), 32'd0);
      next();
      if (k == 2) begin
        d_req[0] = 1'b0;
        d_we[0] = 1'b0;
      end
    end
    next();

    // reset in the middle of a fetch wait
    if_req[0] = 1'b1;
    if_addr[0] = 32'h40;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("r_en", 32'(mem_en[0]), 32'd0);
        chk("r_ack", 32'(if_ack[0]), 32'd0);
        chk("r_addr", mem_addr[0], 32'd0);
        chk("r_irdata", if_rdata[0], 32'd0);
        chk("r_drdata", d_rdata[0], 32'd0);
      end
      if (k == 3) chk("r_ack3", 32'(if_ack[0]), 32'd0);
      if (k == 4) begin
        chk("r_reen", 32'(mem_en[0]), 32'd1);
        chk("r_readdr", mem_addr[0], 32'h40);
      end
      if (k == 7) begin
        chk("r_ack7", 32'(if_ack[0]), 32'd1);
        chk("r_rdata7", if_rdata[0], 32'h2008_0005);
      end
      next();
      if (k == 1) rst = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k == 7) if_req[0] = 1'b0;
    end
    next();

    // latency-1 instance
    if_req[1] = 1'b1;
    if_addr[1] = 32'h40;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) chk("l1_en", 32'(mem_en[1]), 32'd1);
      if (k == 2) chk("l1_ack_lo", 32'(if_ack[1]), 32'd0);
      if (k == 3) begin
        chk("l1_ack", 32'(if_ack[1]), 32'd1);
        chk("l1_rdata", if_rdata[1], 32'h2008_0005);
      end
      next();
      if (k == 3) if_req[1] = 1'b0;
    end
    next();

    // address moves while the fetch is outstanding
    if_req[0] = 1'b1;
    if_addr[0] = 32'h40;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 4) chk("a_en_lo", 32'(mem_en[0]), 32'd0);
      if (k == 3) chk("a_addr", mem_addr[0], 32'h40);
      if (k == 4) begin
        chk("a_ack", 32'(if_ack[0]), 32'd1);
        chk("a_rdata", if_rdata[0], 32'h2008_0005);
      end
      next();
      if (k == 1) if_addr[0] = 32'h80;
      if (k == 4) if_req[0] = 1'b0;
    end
    next();

    // random traffic, mostly protocol-abiding, with rare resets
    rst_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        rst_cnt = $urandom_range(1, 2);
      end
      for (int k = 0; k < 2; k++) begin
        if (if_req[k] && prev_ia[k]) begin
          if_req[k] = 1'($urandom_range(0, 1));
          if_addr[k] = raddr();
        end else if (if_req[k]) begin
          if ($urandom_range(0, 49) == 0) if_addr[k] = raddr();
          else if ($urandom_range(0, 79) == 0) if_req[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          if_req[k] = 1'b1;
          if_addr[k] = raddr();
        end
        if (d_req[k] && prev_da[k]) begin
          d_req[k] = 1'($urandom_range(0, 1));
          d_we[k] = 1'($urandom_range(0, 1));
          d_addr[k] = raddr();
          d_wdata[k] = $urandom;
        end else if (d_req[k]) begin
          if ($urandom_range(0, 49) == 0) d_wdata[k] = $urandom;
          else if ($urandom_range(0, 79) == 0) d_req[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          d_req[k] = 1'b1;
          d_we[k] = 1'($urandom_range(0, 1));
          d_addr[k] = raddr();
          d_wdata[k] = $urandom;
        end
      end
      next();
    end

    quiet();
    rst = 1'b1;
    repeat (8) next();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
